// File: rtl/clk_step_ctrl_if.sv
// Command channel into the clock-step sequencer.
// valid/ready handshake carrying op and step count.
interface clk_step_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/clk_step_ctrl.sv
// Clock-enable sequencer: RUN/HALT/STEP control of a gated
// counter clock, with optional capture pulse on every stop.
module clk_step_ctrl #(
  parameter int CNT_W           = 16,
  parameter bit RESET_RUN       = 1'b1,
  parameter bit CAPTURE_ON_HALT = 1'b1,
  parameter int CAPT_WAIT       = 4
) (
  input  logic             clk,
  input  logic             reset,
  clk_step_ctrl_if.slave   cmd,
  output logic             clk_ce,
  output logic             capture,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] steps_done
);

  localparam int WW = $clog2(CAPT_WAIT + 1);

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    CAPT = 2'b11
  } st_t;

  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  st_t              st, st_n;
  logic             ce_n, cap_n;
  logic [CNT_W-1:0] sd_n, rem, rem_n;
  logic [WW-1:0]    wcnt, w_n;
  logic             acc;

  // Ready only in the idle states; busy is its complement.
  assign cmd.cmd_ready = ~st[1];
  assign busy          = st[1];
  assign state         = st;
  assign acc           = cmd.cmd_valid & cmd.cmd_ready;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= RESET_RUN ? RUN : HALT;
      clk_ce     <= RESET_RUN;
      capture    <= 1'b0;
      steps_done <= '0;
      rem        <= '0;
      wcnt       <= '0;
    end else begin
      st         <= st_n;
      clk_ce     <= ce_n;
      capture    <= cap_n;
      steps_done <= sd_n;
      rem        <= rem_n;
      wcnt       <= w_n;
    end
  end

  // Next-state: command decode, step countdown, capture hold-off.
  always_comb begin
    st_n  = st;
    ce_n  = clk_ce;
    cap_n = 1'b0;
    sd_n  = steps_done;
    rem_n = rem;
    w_n   = wcnt;
    unique case (st)
      HALT: begin
        if (acc) begin
          unique case (cmd.cmd_op)
            OP_RUN: begin
              st_n = RUN;
              ce_n = 1'b1;
            end
            OP_STEP: begin
              if (cmd.cmd_count != '0) begin
                st_n  = STEP;
                ce_n  = 1'b1;
                rem_n = cmd.cmd_count - 1'b1;
                sd_n  = CNT_W'(1);
              end else begin
                sd_n = '0;
              end
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (acc && cmd.cmd_op == OP_HALT) begin
          ce_n = 1'b0;
          if (CAPTURE_ON_HALT) begin
            st_n  = CAPT;
            cap_n = 1'b1;
            w_n   = WW'(CAPT_WAIT - 1);
          end else begin
            st_n = HALT;
          end
        end
      end
      STEP: begin
        if (rem == '0) begin
          ce_n = 1'b0;
          if (CAPTURE_ON_HALT) begin
            st_n  = CAPT;
            cap_n = 1'b1;
            w_n   = WW'(CAPT_WAIT - 1);
          end else begin
            st_n = HALT;
          end
        end else begin
          rem_n = rem - 1'b1;
          if (steps_done != '1)
            sd_n = steps_done + 1'b1;
        end
      end
      CAPT: begin
        ce_n = 1'b0;
        if (wcnt == '0)
          st_n = HALT;
        else
          w_n = wcnt - 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl with default parameters.
// Inputs change 1ns after posedge; outputs checked there.
module tb_clk_step_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_ce, capture, busy;
  logic [1:0]  state;
  logic [15:0] steps_done;
  int          ntests = 0;
  int          nfail  = 0;

  clk_step_ctrl_if #(.CNT_W(16)) bus ();

  clk_step_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (bus),
    .clk_ce     (clk_ce),
    .capture    (capture),
    .busy       (busy),
    .state      (state),
    .steps_done (steps_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] n);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_count = n;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
  endtask

  // After the capture edge: 3 more CAPT cycles, then HALT.
  task automatic capt_tail(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_capt_st"}, 32'(state), 32'h3);
      chk({tag, "_capt_cap"}, 32'(capture), 32'h0);
      chk({tag, "_capt_rdy"}, 32'(bus.cmd_ready), 32'h0);
    end
    tick();
    chk({tag, "_halt_st"}, 32'(state), 32'h0);
    chk({tag, "_halt_rdy"}, 32'(bus.cmd_ready), 32'h1);
    chk({tag, "_halt_ce"}, 32'(clk_ce), 32'h0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_count = '0;
    tick();
    chk("rst_state", 32'(state), 32'h1);
    chk("rst_ce", 32'(clk_ce), 32'h1);
    chk("rst_rdy", 32'(bus.cmd_ready), 32'h1);
    chk("rst_cap", 32'(capture), 32'h0);
    chk("rst_sd", 32'(steps_done), 32'h0);
    reset = 1'b0;

    // STEP and NOP in RUN are ignored
    send(2'b11, 16'd3);
    chk("run_step_st", 32'(state), 32'h1);
    chk("run_step_sd", 32'(steps_done), 32'h0);
    send(2'b00, 16'd0);
    chk("run_nop_ce", 32'(clk_ce), 32'h1);

    // RUN -> HALT with capture
    send(2'b10, 16'd0);
    chk("halt_ce", 32'(clk_ce), 32'h0);
    chk("halt_cap", 32'(capture), 32'h1);
    chk("halt_st", 32'(state), 32'h3);
    chk("halt_busy", 32'(busy), 32'h1);
    capt_tail("halt");

    // HALT/NOP in HALT: no change
    send(2'b10, 16'd0);
    chk("hh_st", 32'(state), 32'h0);
    chk("hh_cap", 32'(capture), 32'h0);

    // STEP N=5
    send(2'b11, 16'd5);
    chk("s5_st", 32'(state), 32'h2);
    chk("s5_ce1", 32'(clk_ce), 32'h1);
    chk("s5_sd1", 32'(steps_done), 32'h1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("s5_ce", 32'(clk_ce), 32'h1);
      chk("s5_sd", 32'(steps_done), 32'(i));
    end
    tick();
    chk("s5_ce_off", 32'(clk_ce), 32'h0);
    chk("s5_cap", 32'(capture), 32'h1);
    chk("s5_sd_end", 32'(steps_done), 32'h5);
    capt_tail("s5");

    // STEP N=0 is a no-op that clears steps_done
    send(2'b11, 16'd0);
    chk("s0_st", 32'(state), 32'h0);
    chk("s0_ce", 32'(clk_ce), 32'h0);
    chk("s0_sd", 32'(steps_done), 32'h0);
    chk("s0_cap", 32'(capture), 32'h0);

    // STEP N=1
    send(2'b11, 16'd1);
    chk("s1_ce", 32'(clk_ce), 32'h1);
    chk("s1_sd", 32'(steps_done), 32'h1);
    tick();
    chk("s1_ce_off", 32'(clk_ce), 32'h0);
    chk("s1_cap", 32'(capture), 32'h1);
    capt_tail("s1");

    // STEP N=3 with RUN held pending
    send(2'b11, 16'd3);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    tick();
    chk("s3_sd2", 32'(steps_done), 32'h2);
    chk("s3_rdy", 32'(bus.cmd_ready), 32'h0);
    tick();
    chk("s3_sd3", 32'(steps_done), 32'h3);
    chk("s3_ce", 32'(clk_ce), 32'h1);
    tick();
    chk("s3_cap", 32'(capture), 32'h1);
    chk("s3_ce_off", 32'(clk_ce), 32'h0);
    capt_tail("s3");
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    chk("s3_run_st", 32'(state), 32'h1);
    chk("s3_run_ce", 32'(clk_ce), 32'h1);

    // Reset during the capture pulse
    send(2'b10, 16'd0);
    chk("rc_cap", 32'(capture), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rc_cap_gone", 32'(capture), 32'h0);
    chk("rc_st", 32'(state), 32'h1);

    // Reset in cycle 2 of STEP N=10
    send(2'b10, 16'd0);
    capt_tail("pre10");
    send(2'b11, 16'd10);
    tick();
    chk("s10_sd2", 32'(steps_done), 32'h2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s10r_st", 32'(state), 32'h1);
    chk("s10r_ce", 32'(clk_ce), 32'h1);
    chk("s10r_sd", 32'(steps_done), 32'h0);
    chk("s10r_cap", 32'(capture), 32'h0);
    tick();
    chk("s10r_cap2", 32'(capture), 32'h0);
    chk("s10r_st2", 32'(state), 32'h1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
